// File: rtl/therm_rx_decoder_pkg.sv
// Shared types and helpers for the thermometer-bus receiver and anything that
// needs to judge or decode a thermometer word (benches, encoder checks).
package therm_rx_decoder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_ERR_W = 8;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_LOCK = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Legal words are (2^n)-1 with the top bit clear.
    function automatic logic is_legal_therm(input logic [DEF_WIDTH-1:0] w);
        logic [DEF_WIDTH-1:0] w_inc;
        w_inc = w + DEF_WIDTH'(1);
        return ((w & w_inc) == '0) && !w[DEF_WIDTH-1];
    endfunction

    function automatic logic [$clog2(DEF_WIDTH+1)-1:0] therm_popcount(input logic [DEF_WIDTH-1:0] w);
        logic [$clog2(DEF_WIDTH+1)-1:0] w_cnt;
        w_cnt = '0;
        for (int i = 0; i < DEF_WIDTH; i++)
            w_cnt = w_cnt + ($clog2(DEF_WIDTH+1))'(w[i]);
        return w_cnt;
    endfunction

endpackage

// File: rtl/therm_rx_decoder_sync_stabilizer.sv
// Synchronizes the asynchronous bus and strobes once when a word has been
// held unchanged for STABLE_CYCLES synchronized samples.
module therm_sync_stabilizer #(
    parameter int WIDTH         = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_therm,
    output logic [WIDTH-1:0] o_word,
    output logic             o_accept
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;
    logic [RUN_W-1:0]                  r_run;
    logic                              r_accept;
    logic [WIDTH-1:0]                  w_s;
    logic [RUN_W-1:0]                  w_run_nxt;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_run_nxt = RUN_W'(1);
        if (w_s == r_prev)
            w_run_nxt = (r_run == RUN_MAX) ? RUN_MAX : r_run + RUN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_prev   <= '0;
            r_run    <= '0;
            r_accept <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_therm};
            r_prev   <= w_s;
            r_run    <= w_run_nxt;
            // Only the cycle the run reaches its limit; a restarted run counts as new.
            r_accept <= (w_run_nxt == RUN_MAX) && ((r_run != RUN_MAX) || (w_s != r_prev));
        end
    end

    // While o_accept is high, r_prev holds exactly the word that stabilized.
    assign o_word   = r_prev;
    assign o_accept = r_accept;

endmodule

// File: rtl/therm_rx_decoder.sv
// Receive side of the thermometer LED bus: validates each stable word, decodes
// it to a count and flags steps, jumps and bubble errors.
module therm_rx_decoder
    import therm_rx_decoder_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = DEF_ERR_W,
    localparam int VAL_W        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] therm_in,
    output logic [VAL_W-1:0] value,
    output logic             value_valid,
    output logic             change_pulse,
    output logic             dir_up,
    output logic             dir_down,
    output logic             jump,
    output logic             bubble_err,
    output logic [ERR_W-1:0] err_count
);

    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_inc;
    logic             w_accept;
    logic             w_legal;
    logic [VAL_W-1:0] w_n;

    therm_sync_stabilizer #(
        .WIDTH         (WIDTH),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stab (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_therm  (therm_in),
        .o_word   (w_word),
        .o_accept (w_accept)
    );

    assign w_inc   = w_word + WIDTH'(1);
    assign w_legal = ((w_word & w_inc) == '0) && !w_word[WIDTH-1];

    // Legal words carry at most WIDTH-1 ones, so VAL_W bits suffice.
    always_comb begin
        w_n = '0;
        for (int i = 0; i < WIDTH; i++)
            w_n = w_n + VAL_W'(w_word[i]);
    end

    state_t           r_state, w_state_nxt;
    logic [VAL_W-1:0] r_value, w_value_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_have_legal, w_have_nxt;
    logic             r_chg, r_up, r_dn, r_jmp, r_bub;
    logic             w_chg, w_up, w_dn, w_jmp, w_bub;
    logic [ERR_W-1:0] r_err_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_value_nxt = r_value;
        w_valid_nxt = r_valid;
        w_have_nxt  = r_have_legal;
        w_chg       = 1'b0;
        w_up        = 1'b0;
        w_dn        = 1'b0;
        w_jmp       = 1'b0;
        w_bub       = 1'b0;
        if (w_accept) begin
            if (!w_legal) begin
                w_state_nxt = ST_ERR;
                w_valid_nxt = 1'b0;
                w_bub       = 1'b1;
            end else begin
                w_state_nxt = ST_LOCK;
                w_valid_nxt = 1'b1;
                w_have_nxt  = 1'b1;
                w_value_nxt = w_n;
                case (r_state)
                    ST_LOCK, ST_ERR: begin
                        // ERR reached straight from WAIT has no prior value to compare.
                        if (r_have_legal && (w_n != r_value)) begin
                            w_chg = 1'b1;
                            w_up  = (w_n > r_value);
                            w_dn  = (w_n < r_value);
                            w_jmp = ((w_n > r_value) ? (w_n - r_value) : (r_value - w_n)) > VAL_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_WAIT;
            r_value      <= '0;
            r_valid      <= 1'b0;
            r_have_legal <= 1'b0;
            r_chg        <= 1'b0;
            r_up         <= 1'b0;
            r_dn         <= 1'b0;
            r_jmp        <= 1'b0;
            r_bub        <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_value      <= w_value_nxt;
            r_valid      <= w_valid_nxt;
            r_have_legal <= w_have_nxt;
            r_chg        <= w_chg;
            r_up         <= w_up;
            r_dn         <= w_dn;
            r_jmp        <= w_jmp;
            r_bub        <= w_bub;
            if (w_bub && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign value        = r_value;
    assign value_valid  = r_valid;
    assign change_pulse = r_chg;
    assign dir_up       = r_up;
    assign dir_down     = r_dn;
    assign jump         = r_jmp;
    assign bubble_err   = r_bub;
    assign err_count    = r_err_cnt;

endmodule

// File: tb/tb_therm_rx_decoder.sv
// Directed bench for therm_rx_decoder: hand-computed expectations, sampled on
// the falling edge, pulses tallied per stimulus window.
module tb_therm_rx_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] therm_in;
    logic [3:0]  value;
    logic        value_valid, change_pulse, dir_up, dir_down, jump, bubble_err;
    logic [7:0]  err_count;

    int n_pass  = 0;
    int n_total = 0;
    int n_chg, n_up, n_dn, n_jmp, n_bub;
    int viol = 0;
    int cyc;
    logic [3:0] val_hist [32];

    always #5 clk = ~clk;

    therm_rx_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .therm_in     (therm_in),
        .value        (value),
        .value_valid  (value_valid),
        .change_pulse (change_pulse),
        .dir_up       (dir_up),
        .dir_down     (dir_down),
        .jump         (jump),
        .bubble_err   (bubble_err),
        .err_count    (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clr();
        n_chg = 0; n_up = 0; n_dn = 0; n_jmp = 0; n_bub = 0;
        cyc = 1;
    endtask

    task automatic step();
        @(negedge clk);
        if (cyc < 32) val_hist[cyc] = value;
        cyc++;
        n_chg += int'(change_pulse);
        n_up  += int'(dir_up);
        n_dn  += int'(dir_down);
        n_jmp += int'(jump);
        n_bub += int'(bubble_err);
        if (change_pulse && bubble_err) viol++;
        if (dir_up && dir_down) viol++;
        if (!change_pulse && (dir_up || dir_down || jump)) viol++;
    endtask

    task automatic drive(input logic [15:0] w, input int n);
        therm_in = w;
        repeat (n) step();
    endtask

    initial begin
        rst_n = 1'b0;
        therm_in = 16'h0000;
        clr();
        repeat (3) step();
        chk("rst_value", value, 0);
        chk("rst_valid", value_valid, 0);
        chk("rst_chg", change_pulse, 0);
        chk("rst_bub", bubble_err, 0);
        chk("rst_err", err_count, 0);
        chk("rst_qual", {dir_up, dir_down, jump}, 0);

        rst_n = 1'b1;
        clr(); drive(16'h0000, 10);
        chk("zero_value", value, 0);
        chk("zero_valid", value_valid, 1);
        chk("zero_nochg", n_chg, 0);
        chk("zero_err", err_count, 0);

        clr(); drive(16'h0007, 12);
        chk("v3_chg", n_chg, 1);
        chk("v3_up", n_up, 1);
        chk("v3_jmp", n_jmp, 1);
        chk("v3_value", value, 3);

        clr(); drive(16'h000F, 12);
        chk("lat_edge6", val_hist[6], 3);
        chk("lat_edge7", val_hist[7], 4);
        chk("v4_chg", n_chg, 1);
        chk("v4_up", n_up, 1);
        chk("v4_dn", n_dn, 0);
        chk("v4_jmp", n_jmp, 0);
        chk("v4_value", value, 4);

        clr(); drive(16'h0007, 12);
        chk("v4to3_chg", n_chg, 1);
        chk("v4to3_dn", n_dn, 1);
        chk("v4to3_jmp", n_jmp, 0);
        chk("v4to3_value", value, 3);

        clr(); drive(16'h7FFF, 12);
        chk("v15_up", n_up, 1);
        chk("v15_jmp", n_jmp, 1);
        chk("v15_value", value, 15);

        clr(); drive(16'h0000, 12);
        chk("wrap_chg", n_chg, 1);
        chk("wrap_dn", n_dn, 1);
        chk("wrap_jmp", n_jmp, 1);
        chk("wrap_value", value, 0);

        clr(); drive(16'h001F, 12);
        chk("load_up", n_up, 1);
        chk("load_jmp", n_jmp, 1);
        chk("load_value", value, 5);

        clr(); drive(16'h000B, 12); drive(16'h8000, 12); drive(16'hFFFF, 12);
        chk("bub_pulses", n_bub, 3);
        chk("bub_nochg", n_chg, 0);
        chk("bub_err", err_count, 3);
        chk("bub_valid", value_valid, 0);
        chk("bub_value", value, 5);

        clr(); drive(16'h0003, 12);
        chk("rec_valid", value_valid, 1);
        chk("rec_value", value, 2);
        chk("rec_chg", n_chg, 1);
        chk("rec_dn", n_dn, 1);
        chk("rec_jmp", n_jmp, 1);
        chk("rec_nobub", n_bub, 0);

        clr(); drive(16'h00FF, 3); drive(16'h0003, 12);
        chk("glitch_nochg", n_chg, 0);
        chk("glitch_nobub", n_bub, 0);
        chk("glitch_value", value, 2);
        chk("glitch_valid", value_valid, 1);

        clr();
        for (int i = 0; i < 252; i++) drive((i % 2) ? 16'h0005 : 16'h000B, 6);
        repeat (8) step();
        chk("sat_pulses", n_bub, 252);
        chk("sat_err", err_count, 255);
        for (int i = 0; i < 8; i++) drive((i % 2) ? 16'h0005 : 16'h000B, 6);
        repeat (8) step();
        chk("sat_hold", err_count, 255);
        chk("sat_valid", value_valid, 0);

        clr(); drive(16'h0001, 12);
        chk("pre_rst_value", value, 1);
        drive(16'h003F, 3);
        rst_n = 1'b0;
        drive(16'h003F, 2);
        chk("mid_rst_value", value, 0);
        chk("mid_rst_valid", value_valid, 0);
        chk("mid_rst_err", err_count, 0);
        chk("mid_rst_pulses", {change_pulse, bubble_err, dir_up, dir_down, jump}, 0);
        rst_n = 1'b1;
        clr(); drive(16'h003F, 12);
        chk("post_rst_value", value, 6);
        chk("post_rst_valid", value_valid, 1);
        chk("post_rst_nochg", n_chg, 0);
        chk("post_rst_nobub", n_bub, 0);

        chk("pulse_rules", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/therm_rx_decoder.md
Name: therm_rx_decoder

Overview:
- Receive end of the thermometer-coded LED bus driven by the counter block; used on the bring-up board to read back the display lines and as an on-chip monitor.
- Synchronizes the 16-bit bus and waits until it has been stable for a set number of cycles.
- Checks that the stable word is a legal thermometer code and decodes it to binary.
- Reports step direction, non-unit jumps (wrap or load), and bubble/over-range errors.

Parameters:
- WIDTH, 16, thermometer bus width. Legal codes are (2^n)-1 for n = 0..WIDTH-1, so bit WIDTH-1 is never legally set.
- SYNC_STAGES, 2, depth of the input synchronizer (minimum 2).
- STABLE_CYCLES, 4, number of consecutive identical synchronized samples required before a word is accepted (minimum 1).
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- therm_in  in  WIDTH  thermometer bus; asynchronous to clk
- value  out  4  decoded count n of the last accepted legal word
- value_valid  out  1  high while the last accepted word was legal
- change_pulse  out  1  one-cycle pulse when an accepted legal value differs from the previous legal value
- dir_up  out  1  qualifies change_pulse: new value > old value
- dir_down  out  1  qualifies change_pulse: new value < old value
- jump  out  1  qualifies change_pulse: absolute difference between new and old value > 1
- bubble_err  out  1  one-cycle pulse when an accepted word is illegal
- err_count  out  ERR_W  saturating count of bubble_err pulses

Behaviour:
- Reset (rst_n low at a clk edge):
  - Synchronizer flops, previous-sample register and run counter are cleared.
  - State goes to WAIT.
  - value = 0, value_valid = 0, all pulses and qualifiers = 0, err_count = 0.
- Synchronizer: SYNC_STAGES-deep flop chain; its last stage is the synchronized sample s.
- Stability tracking:
  - Every cycle: prev <= s; run <= (s == prev) ? sat(run+1) : 1.
  - The run counter saturates at STABLE_CYCLES.
- Accept event: fires on the single cycle in which run transitions to STABLE_CYCLES.
  - Each stable word is evaluated exactly once.
  - Re-acceptance requires the word to change and then re-stabilize.
- Required latency: if therm_in changes between edges 0 and 1 and then holds, outputs update at edge SYNC_STAGES + STABLE_CYCLES + 1 (edge 7 with the defaults).
  - A glitch shorter than STABLE_CYCLES synchronized cycles produces no accept and no output change.
- Legality: word w is legal iff (w & (w+1)) == 0 and w[WIDTH-1] == 0.
  - Decoded n = popcount(w).
- State machine:
  - WAIT: no legal value accepted yet. Legal accept -> LOCK: load value, set value_valid, no change_pulse. Illegal accept -> ERR.
  - LOCK: legal accept with n == value -> stay, no pulse. Legal accept with n != value -> change_pulse plus qualifiers, then value <= n. Illegal accept -> ERR.
  - ERR: value_valid = 0 and value holds the last legal value. Legal accept -> LOCK, and change_pulse fires if n differs from the held value. Illegal accept -> stay, error pulse again.
  - Entering ERR from WAIT leaves value = 0 and suppresses change_pulse on the later recovery; this is tracked with a have_legal flag.
- Pulse and qualifier rules:
  - change_pulse, dir_up, dir_down and jump are registered, high for exactly one cycle, and are 0 when change_pulse is 0.
  - dir_up and dir_down are mutually exclusive.
- Error rules:
  - bubble_err and change_pulse are never high in the same cycle.
  - err_count increments on each bubble_err and saturates at 2^ERR_W - 1.
- Reset mid-operation: any in-flight run is discarded and acceptance restarts from WAIT.
  - After reset, a bus held at 0 is accepted as value 0 with no change_pulse.

Decomposition:
- Shared package contents:
  - State enum (WAIT, LOCK, ERR).
  - Default WIDTH / ERR_W constants.
  - Pure functions is_legal_therm(w) and therm_popcount(w), reusable by benches and by the counter's encoder checks.
- One sub-module, therm_sync_stabilizer:
  - Contains the synchronizer, the prev register and the run counter.
  - Outputs s and a one-cycle accept strobe.
  - Everything else (FSM, decode, pulses, counter) lives in therm_rx_decoder.

Test Plan:
- Reset, then therm_in = 0x0000 held -> at edge 7: value = 0, value_valid = 1, change_pulse = 0, err_count = 0.
- From value 3 (0x0007), drive 0x000F -> exactly one change_pulse with dir_up = 1, jump = 0, value = 4. Then drive 0x0007 -> change_pulse with dir_down = 1, value = 3.
- From value 15 (0x7FFF), drive 0x0000 -> change_pulse with dir_down = 1, jump = 1, value = 0. Load 0x001F from value 0 -> dir_up = 1, jump = 1, value = 5.
- Drive bubble word 0x000B, then 0x8000, then 0xFFFF (over-range) -> three bubble_err pulses, err_count = 3, value_valid = 0, value unchanged. Then 0x0003 -> value_valid = 1, change_pulse as appropriate.
- Legal value 2 with a 3-cycle glitch to 0x00FF -> no accept, no pulse, value stays 2. Force err_count to 255 with repeated bubbles -> stays 255.
- Assert rst_n = 0 during a settling run after 0x003F is applied -> all outputs return to reset values. After release with 0x003F still held: value = 6, value_valid = 1, no change_pulse.
